// File: rtl/hmmm_host_if.sv
// Host-side controller for the hmmm core: loads program words over the shared
// bus, resets and runs the core, and serves core I/O from input/output FIFOs.
// Optional feature macro: HMMM_HOST_CYCLE_CNT_EN enables the run_cycles counter.
module hmmm_host_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned IN_DEPTH   = 4,
    parameter int unsigned OUT_DEPTH  = 4,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WIDTH-1:0]  prog_data,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic              core_rst,
    output logic              core_pgrm_addr,
    output logic              core_pgrm_data,
    input  logic              core_read,
    input  logic              core_write,
    input  logic              core_halt,
    output logic              core_stall,
    input  logic [WIDTH-1:0]  bus_in,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_oe,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [31:0]       run_cycles
);

    localparam int unsigned IPW = $clog2(IN_DEPTH);
    localparam int unsigned OPW = $clog2(OUT_DEPTH);
    localparam int unsigned CW  = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StLdAddr, StLdData, StCrst, StRun, StHalted
    } state_e;

    state_e            state_q, state_d;
    logic              ret_halt_q, ret_halt_d;  // LD_DATA returns to HALTED, not IDLE
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CW-1:0]     rst_cnt_q, rst_cnt_d;

    logic [WIDTH-1:0]  in_mem_q [IN_DEPTH];
    logic [WIDTH-1:0]  in_mem_d [IN_DEPTH];
    logic [IPW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [IPW:0]      in_cnt_q, in_cnt_d;
    logic [WIDTH-1:0]  out_mem_q [OUT_DEPTH];
    logic [WIDTH-1:0]  out_mem_d [OUT_DEPTH];
    logic [OPW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [OPW:0]      out_cnt_q, out_cnt_d;

    logic in_empty, in_full, in_push, in_pop;
    logic out_empty, out_full, out_push, out_pop;

    assign in_empty  = (in_cnt_q == '0);
    assign in_full   = (in_cnt_q == (IPW+1)'(IN_DEPTH));
    assign in_ready  = !in_full;
    assign in_push   = in_valid && !in_full;
    assign out_empty = (out_cnt_q == '0);
    assign out_full  = (out_cnt_q == (OPW+1)'(OUT_DEPTH));
    assign out_valid = !out_empty;
    assign out_data  = out_mem_q[out_rd_q];
    assign out_pop   = out_valid && out_ready;
    assign busy      = (state_q != StIdle) && (state_q != StHalted);
    assign halted    = (state_q == StHalted);

    // Next-state and bus/core control outputs
    always_comb begin
        state_d        = state_q;
        ret_halt_d     = ret_halt_q;
        addr_d         = addr_q;
        data_d         = data_q;
        rst_cnt_d      = rst_cnt_q;
        prog_ready     = 1'b0;
        core_rst       = 1'b1;
        core_pgrm_addr = 1'b0;
        core_pgrm_data = 1'b0;
        core_stall     = 1'b0;
        bus_oe         = 1'b0;
        bus_out        = '0;
        in_pop         = 1'b0;
        out_push       = 1'b0;
        unique case (state_q)
            StIdle, StHalted: begin
                // Not ready while reset is asserted, even though the state reads IDLE
                prog_ready = rst_n;
                if (prog_valid) begin
                    addr_d     = prog_addr;
                    data_d     = prog_data;
                    ret_halt_d = (state_q == StHalted);
                    state_d    = StLdAddr;
                end else if (start) begin
                    rst_cnt_d = '0;
                    state_d   = StCrst;
                end
            end
            StLdAddr: begin
                bus_oe         = 1'b1;
                bus_out        = WIDTH'(addr_q);
                core_pgrm_addr = 1'b1;
                state_d        = StLdData;
            end
            StLdData: begin
                bus_oe         = 1'b1;
                bus_out        = data_q;
                core_pgrm_data = 1'b1;
                state_d        = ret_halt_q ? StHalted : StIdle;
            end
            StCrst: begin
                if (rst_cnt_q == CW'(RST_CYCLES - 1)) state_d = StRun;
                else rst_cnt_d = rst_cnt_q + CW'(1);
            end
            StRun: begin
                core_rst = 1'b0;
                // Halt wins over any I/O request in the same cycle
                if (core_halt) begin
                    state_d = StHalted;
                end else if (core_read) begin
                    if (!in_empty) begin
                        bus_oe  = 1'b1;
                        bus_out = in_mem_q[in_rd_q];
                        in_pop  = 1'b1;
                    end else begin
                        core_stall = 1'b1;
                    end
                end else if (core_write) begin
                    if (!out_full) out_push = 1'b1;
                    else core_stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointer, count and storage updates
    always_comb begin
        in_mem_d  = in_mem_q;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        if (in_push) begin
            in_mem_d[in_wr_q] = in_data;
            in_wr_d           = in_wr_q + IPW'(1);
        end
        if (in_pop) in_rd_d = in_rd_q + IPW'(1);
        if (out_push) begin
            out_mem_d[out_wr_q] = bus_in;
            out_wr_d            = out_wr_q + OPW'(1);
        end
        if (out_pop) out_rd_d = out_rd_q + OPW'(1);
        in_cnt_d  = in_cnt_q + (IPW+1)'(in_push) - (IPW+1)'(in_pop);
        out_cnt_d = out_cnt_q + (OPW+1)'(out_push) - (OPW+1)'(out_pop);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ret_halt_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rst_cnt_q  <= '0;
            in_mem_q   <= '{default: '0};
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_cnt_q   <= '0;
            out_mem_q  <= '{default: '0};
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_halt_q <= ret_halt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rst_cnt_q  <= rst_cnt_d;
            in_mem_q   <= in_mem_d;
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            out_mem_q  <= out_mem_d;
            out_wr_q   <= out_wr_d;
            out_rd_q   <= out_rd_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

`ifdef HMMM_HOST_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Count unstalled RUN cycles; clear on CRST entry, saturate at all-ones
    always_comb begin
        cyc_d = cyc_q;
        if (state_q != StCrst && state_d == StCrst) cyc_d = '0;
        else if (state_q == StRun && !core_stall && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
    end

    // Cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else cyc_q <= cyc_d;
    end

    assign run_cycles = cyc_q;
`else
    assign run_cycles = '0;
`endif

endmodule
